h2c_beat_injector: RTL and testbench
====================================

Name: h2c_beat_injector

Overview:
- Synthesizable H2C stimulus source sitting directly upstream of the shell's QDMA H2C simulation stream (s_axis_qdma_h2c_sim_*).
- Holds a small beat buffer loaded from a side port and replays it as AXI-Stream packets with a fixed inter-packet gap.
- Carries the configuration and data frames that programme and exercise the Menshen pipelines, so benches and on-board self-test no longer hand-drive the stream.

Parameters:
- DATA_WIDTH, 512, tdata width
- DEPTH, 64, buffered beats (power of two)
- GAP_CYCLES, 30, idle cycles after each non-final tlast beat (0 = back-to-back)
- QID_W, 11, tuser_qid width

Ports:
- clk  in  1  stream clock; single clock domain
- rst  in  1  synchronous, active-high reset
- ld_valid  in  1  load beat strobe
- ld_ready  out  1  load accepted when ld_valid && ld_ready
- ld_data  in  DATA_WIDTH  beat data
- ld_mty  in  6  empty bytes, meaningful on last beat
- ld_last  in  1  beat ends a packet
- ld_crc  in  32  CRC, meaningful on last beat
- clear  in  1  empty the buffer (IDLE only)
- start  in  1  begin replay (IDLE only)
- start_qid  in  QID_W  qid applied to the whole replay
- start_mdata  in  32  tuser_mdata applied to the whole replay
- m_axis_tdata  out  DATA_WIDTH
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- m_axis_tuser_mty  out  6
- m_axis_tuser_qid  out  QID_W
- m_axis_tuser_mdata  out  32
- m_axis_tcrc  out  32
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at replay end
- beat_count  out  $clog2(DEPTH)+1  beats stored
- pkt_sent  out  16  tlast handshakes; wraps at 2^16

Behaviour:
- Reset (sync, rst high at edge): state=IDLE, beat_count=0, rd_ptr=0, gap_cnt=0, pkt_sent=0; all outputs 0. Buffer contents are don't-care.
- FSM states are IDLE, SEND and GAP.
- IDLE:
  - ld_ready = !full && !start && !clear.
  - An accepted load writes {data,mty,last,crc} at index beat_count, then beat_count++.
  - clear sets beat_count to 0. clear wins over load and start.
  - start with beat_count>0: latch qid/mdata, rd_ptr=0, go to SEND.
  - start with beat_count==0, or start together with clear: done pulses next cycle and the FSM stays in IDLE.
- SEND:
  - m_axis_tvalid=1. tdata comes from entry rd_ptr.
  - tlast = entry.last OR (rd_ptr==beat_count-1); the final buffered beat always closes a packet.
  - mty and crc are driven from the entry when tlast=1, otherwise 0.
  - qid and mdata are the latched values.
- SEND handshake (tvalid && tready):
  - Final beat: go to IDLE, done=1 next cycle, no gap.
  - tlast beat, not final, GAP_CYCLES>0: go to GAP with gap_cnt=0. If GAP_CYCLES==0, stay in SEND.
  - Any other beat: stay in SEND.
  - In every case rd_ptr++ and the buffer is preserved, so replay is repeatable.
- GAP: tvalid=0. gap_cnt increments each cycle. When gap_cnt==GAP_CYCLES-1, go to SEND. This gives exactly GAP_CYCLES idle cycles.
- Latency: first tvalid is the cycle after start is sampled. Beats within a packet are bubble-free while tready=1.
- AXIS rule: while tvalid && !tready, every m_axis_* output holds stable.
- pkt_sent increments on each tlast handshake.
- In SEND/GAP: ld_ready=0; start and clear are ignored.
- rst mid-replay: takes effect at that edge. tvalid drops, no done pulse, buffer is emptied.

Decomposition:
- Package h2c_inj_pkg:
  - typedef enum state_t {IDLE, SEND, GAP}
  - typedef struct beat_t {data, mty, last, crc}
  - constants MTY_W=6, CRC_W=32
- One sub-module: h2c_inj_beat_ram.
  - DEPTH x beat_t simple dual-port memory.
  - Synchronous write, asynchronous (distributed) read.
  - Keeps storage separate from the FSM.

Test Plan:
- Single beat: load D0=512'h…0900000000, mty=0, last=1, crc=0; start qid=0 mdata=0x4A; tready=1 -> tvalid the cycle after start, tdata=D0, tlast=1, qid=0, mdata=0x0000004A; done the cycle after the handshake; pkt_sent=1.
- Two packets (2 beats + 1 beat), GAP_CYCLES=30 -> beats 0 and 1 on consecutive cycles; tvalid low exactly 30 cycles; beat 2 with tlast; done; pkt_sent=2; no trailing gap.
- Backpressure: tready=0 for 5 cycles on beat 1 of 3 -> tdata, tlast, mty and crc held constant; no beat skipped or duplicated; total handshakes=3.
- Full/overflow: 65 loads into DEPTH=64 -> ld_ready=0 after the 64th; beat_count=64; replay emits 64 beats.
- Boundary:
  - Final beat loaded with last=0 -> tlast forced to 1 on it.
  - start with empty buffer -> done next cycle, tvalid never high.
  - clear+start in the same cycle -> beat_count=0, done pulses.
- Reset mid-replay: rst during beat 3 of 5 -> tvalid=0, busy=0, beat_count=0, pkt_sent=0 after the edge; no done pulse.

Source files
------------

// File: rtl/h2c_inj_pkg.sv
// Shared types and constants for the H2C beat injector.
package h2c_inj_pkg;

  localparam int MTY_W  = 6;
  localparam int CRC_W  = 32;
  localparam int DATA_W = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MTY_W-1:0]  mty;
    logic              last;
    logic [CRC_W-1:0]  crc;
  } beat_t;

endpackage

// File: rtl/h2c_beat_injector_if.sv
// AXI-Stream H2C bus carrying replayed beats towards the QDMA sim port.
interface h2c_beat_injector_if #(
  parameter int DATA_WIDTH = 512,
  parameter int QID_W      = 11
);
  import h2c_inj_pkg::*;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic [MTY_W-1:0]      m_axis_tuser_mty;
  logic [QID_W-1:0]      m_axis_tuser_qid;
  logic [31:0]           m_axis_tuser_mdata;
  logic [CRC_W-1:0]      m_axis_tcrc;

  modport master (
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser_mty,
           m_axis_tuser_qid, m_axis_tuser_mdata, m_axis_tcrc,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser_mty,
           m_axis_tuser_qid, m_axis_tuser_mdata, m_axis_tcrc,
    output m_axis_tready
  );

endinterface

// File: rtl/h2c_inj_beat_ram.sv
// Beat storage: synchronous write, asynchronous (distributed) read.
module h2c_inj_beat_ram #(
  parameter  int W     = 551,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write one beat per accepted load; contents need no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/h2c_beat_injector.sv
// Buffers beats from a load port and replays them as AXI-Stream packets
// with a fixed idle gap between packets.
module h2c_beat_injector
  import h2c_inj_pkg::*;
#(
  parameter  int DATA_WIDTH = 512,
  parameter  int DEPTH      = 64,
  parameter  int GAP_CYCLES = 30,
  parameter  int QID_W      = 11,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [MTY_W-1:0]      ld_mty,
  input  logic                  ld_last,
  input  logic [CRC_W-1:0]      ld_crc,
  input  logic                  clear,
  input  logic                  start,
  input  logic [QID_W-1:0]      start_qid,
  input  logic [31:0]           start_mdata,
  h2c_beat_injector_if.master   axis,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         beat_count,
  output logic [15:0]           pkt_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = DATA_WIDTH + MTY_W + 1 + CRC_W;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                r_state;
  logic [CW-1:0]         r_beat_count;
  logic [CW-1:0]         r_rd_ptr;
  logic [GW-1:0]         r_gap_cnt;
  logic [15:0]           r_pkt_sent;
  logic                  r_done;
  logic [QID_W-1:0]      r_qid;
  logic [31:0]           r_mdata;
  logic                  r_tvalid;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tlast;
  logic [MTY_W-1:0]      r_mty;
  logic [CRC_W-1:0]      r_crc;

  logic                  w_full;
  logic                  w_ld_ready;
  logic                  w_ld_fire;
  logic                  w_hs;
  logic                  w_final;
  logic                  w_present;
  logic [CW-1:0]         w_last_idx;
  logic [CW-1:0]         w_rd_idx;
  logic [BW-1:0]         w_rd_word;
  logic                  w_rd_tlast;

  assign w_full     = (r_beat_count == CW'(DEPTH));
  assign w_ld_ready = (r_state == IDLE) && !w_full && !start && !clear;
  assign w_ld_fire  = ld_valid && w_ld_ready;
  assign w_last_idx = r_beat_count - CW'(1);
  assign w_hs       = r_tvalid && axis.m_axis_tready;
  assign w_final    = (r_rd_ptr == w_last_idx);

  // Read address is the beat about to be presented on the next edge.
  always_comb begin
    w_rd_idx = '0;
    case (r_state)
      IDLE:    w_rd_idx = '0;
      SEND:    w_rd_idx = r_rd_ptr + CW'(1);
      GAP:     w_rd_idx = r_rd_ptr;
      default: w_rd_idx = '0;
    endcase
  end

  // Decide whether a new beat is loaded into the output registers this edge.
  always_comb begin
    w_present = 1'b0;
    case (r_state)
      IDLE:    w_present = start && !clear && (r_beat_count != '0);
      SEND:    w_present = w_hs && !w_final && !(r_tlast && (GAP_CYCLES > 0));
      GAP:     w_present = (r_gap_cnt == GAP_LAST);
      default: w_present = 1'b0;
    endcase
  end

  h2c_inj_beat_ram #(.W(BW), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .i_we    (w_ld_fire),
    .i_waddr (r_beat_count[AW-1:0]),
    .i_wdata ({ld_data, ld_mty, ld_last, ld_crc}),
    .i_raddr (w_rd_idx[AW-1:0]),
    .o_rdata (w_rd_word)
  );

  // The last buffered beat always closes a packet even if loaded without last.
  assign w_rd_tlast = w_rd_word[CRC_W] || (w_rd_idx == w_last_idx);

  // Replay FSM with registered stream outputs and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_beat_count <= '0;
      r_rd_ptr     <= '0;
      r_gap_cnt    <= '0;
      r_pkt_sent   <= '0;
      r_done       <= 1'b0;
      r_qid        <= '0;
      r_mdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_tlast      <= 1'b0;
      r_mty        <= '0;
      r_crc        <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_ld_fire) begin
        r_beat_count <= r_beat_count + CW'(1);
      end
      if (w_present) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_rd_word[BW-1 -: DATA_WIDTH];
        r_tlast  <= w_rd_tlast;
        r_mty    <= w_rd_tlast ? w_rd_word[CRC_W+1 +: MTY_W] : '0;
        r_crc    <= w_rd_tlast ? w_rd_word[CRC_W-1:0] : '0;
      end else if (w_hs) begin
        r_tvalid <= 1'b0;
        r_tdata  <= '0;
        r_tlast  <= 1'b0;
        r_mty    <= '0;
        r_crc    <= '0;
      end
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_beat_count <= '0;
            r_done       <= start;
          end else if (start) begin
            if (r_beat_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_qid    <= start_qid;
              r_mdata  <= start_mdata;
              r_rd_ptr <= '0;
              r_state  <= SEND;
            end
          end
        end
        SEND: begin
          if (w_hs) begin
            r_rd_ptr <= r_rd_ptr + CW'(1);
            if (r_tlast) begin
              r_pkt_sent <= r_pkt_sent + 16'd1;
            end
            if (w_final) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else if (r_tlast && (GAP_CYCLES > 0)) begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ld_ready                = w_ld_ready;
  assign busy                    = (r_state != IDLE);
  assign done                    = r_done;
  assign beat_count              = r_beat_count;
  assign pkt_sent                = r_pkt_sent;
  assign axis.m_axis_tvalid      = r_tvalid;
  assign axis.m_axis_tdata       = r_tdata;
  assign axis.m_axis_tlast       = r_tlast;
  assign axis.m_axis_tuser_mty   = r_mty;
  assign axis.m_axis_tcrc        = r_crc;
  assign axis.m_axis_tuser_qid   = r_qid;
  assign axis.m_axis_tuser_mdata = r_mdata;

endmodule

// File: tb/tb_h2c_beat_injector.sv
// Directed/randomized bench for h2c_beat_injector with a queue-based model.
module tb_h2c_beat_injector;
  import h2c_inj_pkg::*;

  localparam int DW = 512;
  localparam int DEPTH = 64;
  localparam int GAP = 30;
  localparam int QW = 11;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_valid = 1'b0;
  logic ld_ready;
  logic [DW-1:0] ld_data = '0;
  logic [5:0] ld_mty = '0;
  logic ld_last = 1'b0;
  logic [31:0] ld_crc = '0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic [QW-1:0] start_qid = '0;
  logic [31:0] start_mdata = '0;
  logic busy, done;
  logic [CW-1:0] beat_count;
  logic [15:0] pkt_sent;

  h2c_beat_injector_if #(.DATA_WIDTH(DW), .QID_W(QW)) bus ();

  h2c_beat_injector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .QID_W(QW)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_mty(ld_mty), .ld_last(ld_last), .ld_crc(ld_crc), .clear(clear), .start(start),
    .start_qid(start_qid), .start_mdata(start_mdata), .axis(bus), .busy(busy),
    .done(done), .beat_count(beat_count), .pkt_sent(pkt_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  beat_t mq[$];          // model of buffer contents
  logic [15:0] exp_pkts = 16'd0;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic beat_t rand_beat(input logic last);
    beat_t b;
    b.data = rand512();
    b.mty  = 6'($urandom_range(0, 63));
    b.last = last;
    b.crc  = $urandom;
    return b;
  endfunction

  function automatic logic [639:0] bus_vec();
    return 640'({bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser_mty, bus.m_axis_tcrc,
                 bus.m_axis_tuser_qid, bus.m_axis_tuser_mdata});
  endfunction

  task automatic load(input beat_t b, output bit acc);
    ld_valid = 1'b1; ld_data = b.data; ld_mty = b.mty; ld_last = b.last; ld_crc = b.crc;
    @(negedge clk);
    acc = ld_ready;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    if (acc) mq.push_back(b);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    mq.delete();
    chk("clear_count", 640'(beat_count), 640'(0));
  endtask

  // mode: 0 = tready always 1, 1 = random tready, 2 = stall 5 cycles on beat 1
  task automatic do_replay(input string nm, input logic [QW-1:0] qid, input logic [31:0] md,
                           input int mode, input bit with_clear);
    beat_t e;
    beat_t expq[$];
    logic [639:0] obs_v[$];
    int obs_c[$];
    logic [639:0] snap;
    bit hold = 1'b0;
    bit got_done = 1'b0;
    int done_cyc = -1, first_v = -1, n_valid = 0, stalls = 0, s;
    logic tl;

    if (with_clear) mq.delete();
    for (int i = 0; i < mq.size(); i++) begin
      tl = mq[i].last || (i == mq.size() - 1);
      e.data = mq[i].data; e.last = tl;
      e.mty  = tl ? mq[i].mty : 6'd0;
      e.crc  = tl ? mq[i].crc : 32'd0;
      expq.push_back(e);
      if (tl) exp_pkts = exp_pkts + 16'd1;
    end

    start = 1'b1; start_qid = qid; start_mdata = md; clear = with_clear;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0; s = cyc;
    for (int c = 0; c < 3000; c++) begin
      if (mode == 1) bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && obs_v.size() == 1 && stalls < 5) begin
        bus.m_axis_tready = 1'b0; stalls++;
      end else bus.m_axis_tready = 1'b1;
      @(negedge clk);
      if (done) begin got_done = 1'b1; done_cyc = cyc; end
      if (bus.m_axis_tvalid) begin n_valid++; if (first_v < 0) first_v = cyc; end
      if (hold) begin
        chk({nm, "_hold"}, 640'({bus.m_axis_tvalid, bus_vec()}), 640'({1'b1, snap}));
        hold = 1'b0;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        obs_v.push_back(bus_vec()); obs_c.push_back(cyc);
      end else if (bus.m_axis_tvalid) begin
        snap = bus_vec(); hold = 1'b1;
      end
      if (got_done) break;
      @(posedge clk); #1;
    end

    chk({nm, "_done_seen"}, 640'(got_done), 640'(1));
    chk({nm, "_beats"}, 640'(obs_v.size()), 640'(expq.size()));
    for (int i = 0; i < expq.size() && i < obs_v.size(); i++)
      chk($sformatf("%s_beat%0d", nm, i), obs_v[i],
          640'({expq[i].data, expq[i].last, expq[i].mty, expq[i].crc, qid, md}));
    if (expq.size() == 0) begin
      chk({nm, "_done_cyc"}, 640'(done_cyc), 640'(s));
      chk({nm, "_no_valid"}, 640'(n_valid), 640'(0));
    end else begin
      chk({nm, "_first_valid"}, 640'(first_v), 640'(s));
      if (obs_c.size() > 0)
        chk({nm, "_done_cyc"}, 640'(done_cyc), 640'(obs_c[obs_c.size() - 1] + 1));
    end
    if (mode == 0) begin
      for (int i = 1; i < obs_c.size() && i < expq.size(); i++)
        chk($sformatf("%s_spacing%0d", nm, i), 640'(obs_c[i] - obs_c[i-1]),
            640'((expq[i-1].last && GAP > 0) ? GAP + 1 : 1));
    end
    @(posedge clk); @(negedge clk);
    chk({nm, "_done_pulse"}, 640'({done, bus.m_axis_tvalid, busy}), 640'(0));
    chk({nm, "_pkt_sent"}, 640'(pkt_sent), 640'(exp_pkts));
    @(posedge clk); #1;
  endtask

  initial begin
    bit acc;
    int nacc;
    int hs;
    int ndone;
    beat_t b;

    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", 640'({bus.m_axis_tvalid, busy, done, bus.m_axis_tlast}), 640'(0));
    chk("rst_bus", bus_vec(), 640'(0));
    chk("rst_count", 640'({beat_count, pkt_sent}), 640'(0));
    chk("rst_ld_ready", 640'(ld_ready), 640'(1));
    @(posedge clk); #1;

    // Single beat
    b.data = '0; b.data[39:0] = 40'h0900000000; b.mty = 6'd0; b.last = 1'b1; b.crc = 32'd0;
    load(b, acc);
    chk("single_acc", 640'(acc), 640'(1));
    do_replay("single", 11'd0, 32'h0000004A, 0, 1'b0);

    // Two packets: 2 beats + 1 beat
    do_clear();
    load(rand_beat(1'b0), acc); load(rand_beat(1'b1), acc); load(rand_beat(1'b1), acc);
    chk("two_count", 640'(beat_count), 640'(3));
    do_replay("two_pkt", 11'($urandom), $urandom, 0, 1'b0);
    // Replay is repeatable from the preserved buffer
    do_replay("two_pkt_again", 11'($urandom), $urandom, 0, 1'b0);

    // Backpressure on beat 1 of 3
    do_clear();
    for (int i = 0; i < 3; i++) load(rand_beat(1'($urandom)), acc);
    do_replay("bp", 11'($urandom), $urandom, 2, 1'b0);

    // Random contents with random backpressure
    for (int it = 0; it < 3; it++) begin
      do_clear();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) load(rand_beat(1'($urandom)), acc);
      do_replay($sformatf("rnd%0d", it), 11'($urandom), $urandom, 1, 1'b0);
    end

    // Full/overflow with no last flags: one 64-beat packet, final tlast forced
    do_clear();
    nacc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      load(rand_beat(1'b0), acc);
      if (acc) nacc++;
    end
    load(rand_beat(1'b0), acc);
    chk("full_65th_rejected", 640'(acc), 640'(0));
    chk("full_accepted", 640'(nacc), 640'(DEPTH));
    chk("full_count", 640'(beat_count), 640'(DEPTH));
    chk("full_ld_ready", 640'(ld_ready), 640'(0));
    do_replay("full", 11'($urandom), $urandom, 0, 1'b0);

    // Empty start
    do_clear();
    do_replay("empty", 11'($urandom), $urandom, 0, 1'b0);

    // clear together with start
    load(rand_beat(1'b1), acc); load(rand_beat(1'b0), acc);
    do_replay("clr_start", 11'($urandom), $urandom, 0, 1'b1);
    chk("clr_start_count", 640'(beat_count), 640'(0));

    // Reset during beat 3 of 5
    do_clear();
    for (int i = 0; i < 5; i++) load(rand_beat(1'b0), acc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 200 && hs < 2; c++) begin
      @(negedge clk);
      if (bus.m_axis_tvalid && bus.m_axis_tready) hs++;
      @(posedge clk); #1;
    end
    chk("mid_rst_reached", 640'(hs), 640'(2));
    chk("mid_rst_presenting", 640'(bus.m_axis_tvalid), 640'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); exp_pkts = 16'd0;
    chk("mid_rst_state", 640'({bus.m_axis_tvalid, busy, done}), 640'(0));
    chk("mid_rst_count", 640'({beat_count, pkt_sent}), 640'(0));
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || bus.m_axis_tvalid) ndone++;
      @(posedge clk); #1;
    end
    chk("mid_rst_quiet", 640'(ndone), 640'(0));

    // Recovery after reset
    load(rand_beat(1'b1), acc); load(rand_beat(1'b0), acc);
    do_replay("post_rst", 11'($urandom), $urandom, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
